serial_link_arbiter: RTL

Transmit-side controller for the NeXT serial link. It shares one serial output line between up to four requesters, each offering 40-bit frames. It grants one frame at a time and serializes it with the same framing the link receiver expects: a 1 start bit, then 40 data bits LSB first, then a low guard gap. It sits between the audio/keyboard command sources and the pad driving the link data line.

---
 rtl/nextasic_link_pkg.sv | 17 +
 rtl/link_tx_shifter.sv | 92 +++++++++
 rtl/serial_link_arbiter.sv | 104 ++++++++++
 3 files changed

// File: rtl/nextasic_link_pkg.sv
// Shared definitions for the NeXT serial link transmit and receive blocks:
// frame geometry, line levels and the transmit sequencer state encoding.
package nextasic_link_pkg;

  localparam int   FRAME_BITS  = 40;
  localparam int   MIN_GAP     = 2;
  localparam logic START_LEVEL = 1'b1;
  localparam logic IDLE_LEVEL  = 1'b0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_GAP
  } link_state_t;

endpackage

// File: rtl/link_tx_shifter.sv
// Frame serializer: start bit, 40 data bits LSB first, then GAP_CYCLES low cycles.
// The serial output is registered, so each line value is prepared one edge ahead.
module link_tx_shifter
  import nextasic_link_pkg::*;
#(
  parameter int GAP_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_load,
  input  logic [FRAME_BITS-1:0] i_data,
  output logic                  o_so,
  output logic                  o_busy,
  output logic                  o_idle,
  output logic                  o_frame_done
);

  localparam int GCW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [5:0]     LAST_BIT = 6'(FRAME_BITS - 1);
  localparam logic [GCW-1:0] LAST_GAP = GCW'(GAP_CYCLES - 1);

  link_state_t           r_state, w_state_next;
  logic [FRAME_BITS-1:0] r_shift, w_shift_next;
  logic [5:0]            r_bit_cnt, w_bit_cnt_next;
  logic [GCW-1:0]        r_gap_cnt, w_gap_cnt_next;
  logic                  r_so, w_so_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_gap_cnt <= '0;
      r_so      <= IDLE_LEVEL;
    end else begin
      r_state   <= w_state_next;
      r_shift   <= w_shift_next;
      r_bit_cnt <= w_bit_cnt_next;
      r_gap_cnt <= w_gap_cnt_next;
      r_so      <= w_so_next;
    end
  end

  // w_so_next is the line value for the cycle after this edge.
  always_comb begin
    w_state_next   = r_state;
    w_shift_next   = r_shift;
    w_bit_cnt_next = r_bit_cnt;
    w_gap_cnt_next = r_gap_cnt;
    w_so_next      = IDLE_LEVEL;
    case (r_state)
      S_IDLE: begin
        if (i_load) begin
          w_state_next = S_START;
          w_shift_next = i_data;
          w_so_next    = START_LEVEL;
        end
      end
      S_START: begin
        w_state_next   = S_DATA;
        w_bit_cnt_next = '0;
        w_so_next      = r_shift[0];
        w_shift_next   = r_shift >> 1;
      end
      S_DATA: begin
        if (r_bit_cnt == LAST_BIT) begin
          w_state_next   = S_GAP;
          w_gap_cnt_next = '0;
        end else begin
          w_bit_cnt_next = r_bit_cnt + 6'd1;
          w_so_next      = r_shift[0];
          w_shift_next   = r_shift >> 1;
        end
      end
      S_GAP: begin
        if (r_gap_cnt == LAST_GAP) begin
          w_state_next   = S_IDLE;
          w_gap_cnt_next = '0;
        end else begin
          w_gap_cnt_next = r_gap_cnt + GCW'(1);
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign o_so         = r_so;
  assign o_busy       = (r_state != S_IDLE);
  assign o_idle       = (r_state == S_IDLE);
  assign o_frame_done = (r_state == S_GAP) && (r_gap_cnt == LAST_GAP);

endmodule

// File: rtl/serial_link_arbiter.sv
// Shares one serial link line between NREQ frame requesters.
// SERIAL_LINK_ARB_RR_EN selects round-robin; otherwise the lowest index wins.
module serial_link_arbiter
  import nextasic_link_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int GAP  = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ*FRAME_BITS-1:0] req_data,
  output logic [NREQ-1:0]            req_ready,
  output logic                       so,
  output logic                       busy,
  output logic [1:0]                 grant_id,
  output logic                       frame_done
);

  logic                  w_idle;
  logic                  w_found;
  logic [1:0]            w_winner;
  logic                  w_accept;
  logic [FRAME_BITS-1:0] w_frame;
  logic [1:0]            r_grant;

`ifdef SERIAL_LINK_ARB_RR_EN
  logic [1:0] r_last;

  // Search starts just after the last granted requester and wraps.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    for (int k = 1; k <= NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!w_found && req_valid[i] && (i == ((int'(r_last) + k) % NREQ))) begin
          w_found  = 1'b1;
          w_winner = 2'(i);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= 2'(NREQ - 1);
    end else if (w_accept) begin
      r_last <= w_winner;
    end
  end
`else
  always_comb begin
    w_found  = |req_valid;
    w_winner = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_valid[k]) begin
        w_winner = 2'(k);
      end
    end
  end
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_ready
      assign req_ready[gi] = w_idle && w_found && (w_winner == 2'(gi));
    end
  endgenerate

  assign w_accept = |(req_valid & req_ready);

  always_comb begin
    w_frame = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_winner == 2'(i)) begin
        w_frame = req_data[i*FRAME_BITS +: FRAME_BITS];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_grant <= '0;
    end else if (w_accept) begin
      r_grant <= w_winner;
    end
  end

  assign grant_id = r_grant;

  link_tx_shifter #(
    .GAP_CYCLES(GAP)
  ) u_shifter (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_accept),
    .i_data      (w_frame),
    .o_so        (so),
    .o_busy      (busy),
    .o_idle      (w_idle),
    .o_frame_done(frame_done)
  );

endmodule
